// File: rtl/nios2_oci_pkg.sv
// Shared definitions for the OCI monitor bridge: FSM states, jdo field layout,
// and the default access timeout.
package nios2_oci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR
    } mon_state_t;

    // Field positions inside the 38-bit jdo payload.
    localparam int unsigned JDO_ADDR_LSB = 17;
    localparam int unsigned JDO_RD_BIT   = 34;
    localparam int unsigned JDO_DATA_LSB = 3;
    localparam int unsigned JDO_DATA_MSB = 34;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/nios2_oci_timeout_cnt.sv
// Loadable down-counter that flags when a pending monitor access has waited
// TIMEOUT cycles. Loading TIMEOUT-1 makes 'expired' true on the TIMEOUT-th
// cycle spent in the access state.
module nios2_oci_timeout_cnt
    import nios2_oci_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT - 1);

    logic [15:0] count;

    // Reload on access entry, otherwise count down while enabled and saturate at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 16'd1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/nios2_oci_monitor_bridge.sv
// Turns debug-module ocimem strobes into single-word reads/writes on the
// on-chip debug memory window, with address auto-increment, timeout and a
// sticky error flag reported back to the JTAG side.
module nios2_oci_monitor_bridge
    import nios2_oci_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mon_addr,
    output logic [31:0]       mon_wdata,
    output logic              mon_rd,
    output logic              mon_wr,
    input  logic [31:0]       mon_rdata,
    input  logic              mon_ack
);

    mon_state_t        state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [31:0]       dreg_nx;
    logic              ready_nx;
    logic              error_nx;
    logic              cnt_load;
    logic              expired;
    logic              strobe_any;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_data;
    logic              unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_data   = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    nios2_oci_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .en      (state != ST_IDLE),
        .expired (expired)
    );

    // Next-state and register-update decode; write strobe wins over address load,
    // which wins over plain read. mon_ack beats a same-cycle timeout.
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        dreg_nx  = MonDReg;
        ready_nx = monitor_ready;
        error_nx = monitor_error;
        cnt_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_action_ocimem_b) begin
                    dreg_nx  = jdo_data;
                    ready_nx = 1'b0;
                    state_nx = ST_WR;
                    cnt_load = 1'b1;
                end else if (take_action_ocimem_a) begin
                    addr_nx  = jdo_addr;
                    error_nx = 1'b0;
                    ready_nx = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state_nx = ST_RD;
                        cnt_load = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    ready_nx = 1'b0;
                    state_nx = ST_RD;
                    cnt_load = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                if (strobe_any) begin
                    error_nx = 1'b1;
                end
                if (mon_ack) begin
                    if (state == ST_RD) begin
                        dreg_nx = mon_rdata;
                    end
                    ready_nx = 1'b1;
                    addr_nx  = addr + ADDR_W'(1);
                    state_nx = ST_IDLE;
                end else if (expired) begin
                    error_nx = 1'b1;
                    ready_nx = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_nx;
            addr          <= addr_nx;
            MonDReg       <= dreg_nx;
            monitor_ready <= ready_nx;
            monitor_error <= error_nx;
        end
    end

    assign mon_addr  = addr;
    assign mon_wdata = MonDReg;
    assign mon_rd    = (state == ST_RD);
    assign mon_wr    = (state == ST_WR);

endmodule
